// File: rtl/da_rom_sequencer.sv
// Distributed-arithmetic ROM sequencer: walks the bit-slices of four samples
// MSB-first, drives the coefficient ROM address, and shift-accumulates the
// ROM words into a full-precision signed dot product.
module da_rom_sequencer #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned ROM_W = 17,
  parameter int unsigned ACC_W = IN_W + ROM_W + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         x0,
  input  logic [IN_W-1:0]         x1,
  input  logic [IN_W-1:0]         x2,
  input  logic [IN_W-1:0]         x3,
  output logic                    rom_cs,
  output logic [3:0]              rom_addr,
  input  logic [ROM_W-1:0]        rom_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data
);

  localparam int unsigned      J_W   = $clog2(IN_W);
  localparam logic [J_W-1:0]   J_TOP = J_W'(IN_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    in_ready_d;
  logic                    rom_cs_d;
  logic [3:0]              rom_addr_d;
  logic                    out_valid_d;
  logic signed [ACC_W-1:0] out_data_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [IN_W-1:0]         x0_q, x1_q, x2_q, x3_q;
  logic [IN_W-1:0]         x0_d, x1_d, x2_d, x3_d;
  logic [J_W-1:0]          j_q, j_d;
  logic signed [ACC_W-1:0] rom_ext;

  // Gather bit idx of each sample into a ROM address.
  function automatic logic [3:0] slice_at(
    input logic [IN_W-1:0] a,
    input logic [IN_W-1:0] b,
    input logic [IN_W-1:0] c,
    input logic [IN_W-1:0] d,
    input logic [J_W-1:0]  idx
  );
    return {d[idx], c[idx], b[idx], a[idx]};
  endfunction

  // ROM words are unsigned; widen without sign extension.
  assign rom_ext = $signed(ACC_W'(rom_data));

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready;
    rom_cs_d    = rom_cs;
    rom_addr_d  = rom_addr;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    acc_d       = acc_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    x3_d        = x3_q;
    j_d         = j_q;

    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        rom_cs_d   = 1'b0;
        rom_addr_d = 4'd0;
        if (in_valid && in_ready) begin
          x0_d       = x0;
          x1_d       = x1;
          x2_d       = x2;
          x3_d       = x3;
          j_d        = J_TOP;
          rom_cs_d   = 1'b1;
          rom_addr_d = slice_at(x0, x1, x2, x3, J_TOP);
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end

      RUN: begin
        in_ready_d = 1'b0;
        // The sign slice carries negative weight in two's complement.
        if (j_q == J_TOP) begin
          acc_d = -rom_ext;
        end else begin
          acc_d = (acc_q <<< 1) + rom_ext;
        end
        if (j_q == '0) begin
          out_data_d  = acc_d;
          out_valid_d = 1'b1;
          rom_cs_d    = 1'b0;
          rom_addr_d  = 4'd0;
          state_d     = DONE;
        end else begin
          j_d        = j_q - J_W'(1);
          rom_addr_d = slice_at(x0_q, x1_q, x2_q, x3_q, j_q - J_W'(1));
        end
      end

      DONE: begin
        in_ready_d  = 1'b0;
        rom_cs_d    = 1'b0;
        out_valid_d = 1'b1;
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b0;
        rom_cs_d    = 1'b0;
        rom_addr_d  = 4'd0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b0;
      rom_cs    <= 1'b0;
      rom_addr  <= 4'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      acc_q     <= '0;
      x0_q      <= '0;
      x1_q      <= '0;
      x2_q      <= '0;
      x3_q      <= '0;
      j_q       <= '0;
    end else begin
      state_q   <= state_d;
      in_ready  <= in_ready_d;
      rom_cs    <= rom_cs_d;
      rom_addr  <= rom_addr_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      acc_q     <= acc_d;
      x0_q      <= x0_d;
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      x3_q      <= x3_d;
      j_q       <= j_d;
    end
  end

endmodule

// File: tb/tb_da_rom_sequencer.sv
// Bench for da_rom_sequencer with a c4 coefficient ROM model and a result
// scoreboard.
module tb_da_rom_sequencer;

  localparam int unsigned IN_W  = 16;
  localparam int unsigned ROM_W = 17;
  localparam int unsigned ACC_W = IN_W + ROM_W + 1;
  localparam longint      C4    = 11585;

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [IN_W-1:0]         x0, x1, x2, x3;
  logic                    rom_cs;
  logic [3:0]              rom_addr;
  logic [ROM_W-1:0]        rom_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint exp_q[$];

  da_rom_sequencer #(.IN_W(IN_W), .ROM_W(ROM_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  // Clock: period 10, posedge at 5, 15, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: every sample weighted by c4, so word = popcount(addr) * c4.
  assign rom_data = ROM_W'(longint'($countones(rom_addr)) * C4);

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint ref_dot(input logic [IN_W-1:0] a, b, c, d);
    return (longint'($signed(a)) + longint'($signed(b)) +
            longint'($signed(c)) + longint'($signed(d))) * C4;
  endfunction

  function automatic logic [3:0] ref_slice(input logic [IN_W-1:0] a, b, c, d, input int j);
    return {d[j], c[j], b[j], a[j]};
  endfunction

  // Drive in_valid at a negedge and wait (bounded) until the DUT is ready.
  task automatic offer(input logic [IN_W-1:0] a, b, c, d);
    int n;
    @(negedge clk);
    x0 = a; x1 = b; x2 = c; x3 = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("accept_timeout", 0, 1);
  endtask

  // One full transaction: accept, RUN address walk, DONE with backpressure.
  task automatic do_txn(input logic [IN_W-1:0] a, b, c, d, input int hold);
    longint exp_v;
    longint held;
    offer(a, b, c, d);
    exp_q.push_back(ref_dot(a, b, c, d));
    @(negedge clk);
    in_valid = 1'b0;
    x0 = IN_W'($urandom); x1 = IN_W'($urandom);
    x2 = IN_W'($urandom); x3 = IN_W'($urandom);
    check_eq("run_in_ready", longint'(in_ready), 0);
    check_eq("run_rom_cs", longint'(rom_cs), 1);
    for (int j = IN_W - 1; j >= 0; j--) begin
      check_eq("rom_addr", longint'(rom_addr), longint'(ref_slice(a, b, c, d, j)));
      check_eq("run_out_valid", longint'(out_valid), 0);
      @(negedge clk);
    end
    check_eq("latency_out_valid", longint'(out_valid), 1);
    check_eq("done_rom_cs", longint'(rom_cs), 0);
    check_eq("done_rom_addr", longint'(rom_addr), 0);
    check_eq("done_in_ready", longint'(in_ready), 0);
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", 0, 1);
    end else begin
      exp_v = exp_q.pop_front();
      check_eq("out_data", longint'(out_data), exp_v);
    end
    held = longint'(out_data);
    // Offer a competing group during backpressure; it must not be taken.
    in_valid = (hold > 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("bp_out_valid", longint'(out_valid), 1);
      check_eq("bp_out_data", longint'(out_data), held);
      check_eq("bp_in_ready", longint'(in_ready), 0);
      check_eq("bp_rom_cs", longint'(rom_cs), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("ret_out_valid", longint'(out_valid), 0);
    check_eq("ret_in_ready", longint'(in_ready), 1);
    check_eq("ret_out_data_held", longint'(out_data), held);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, longint'(in_ready), 0);
    check_eq({tag, "_rom_cs"}, longint'(rom_cs), 0);
    check_eq({tag, "_rom_addr"}, longint'(rom_addr), 0);
    check_eq({tag, "_out_valid"}, longint'(out_valid), 0);
    check_eq({tag, "_out_data"}, longint'(out_data), 0);
  endtask

  initial begin
    int seen_valid;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x0 = '0; x1 = '0; x2 = '0; x3 = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    #1 rst_n = 1'b1;
    #1 check_eq("rel_in_ready_low", longint'(in_ready), 0);
    @(negedge clk);
    check_eq("rel_in_ready_high", longint'(in_ready), 1);

    do_txn(16'h0001, 16'h0000, 16'h0000, 16'h0000, 0);
    do_txn(16'h0001, 16'h0001, 16'h0001, 16'h0001, 0);
    do_txn(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 0);
    do_txn(16'h8000, 16'h8000, 16'h8000, 16'h8000, 0);
    do_txn(16'h0001, 16'h0002, 16'h0004, 16'h0008, 5);
    for (int r = 0; r < 4; r++) begin
      do_txn(IN_W'($urandom), IN_W'($urandom), IN_W'($urandom), IN_W'($urandom),
             int'($urandom_range(0, 2)));
    end

    // Reset while the walk is at slice 7; the partial result is dropped.
    offer(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (IN_W - 1 - 7) @(negedge clk);
    check_eq("mid_rom_addr_j7", longint'(rom_addr),
             longint'(ref_slice(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 7)));
    rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    seen_valid = 0;
    repeat (2) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1;
    end
    #1 rst_n = 1'b1;
    #1 check_eq("mid_rel_in_ready_low", longint'(in_ready), 0);
    @(negedge clk);
    check_eq("mid_rel_in_ready_high", longint'(in_ready), 1);
    repeat (IN_W) begin
      if (out_valid) seen_valid = 1;
      @(negedge clk);
    end
    check_eq("mid_no_out_valid", longint'(seen_valid), 0);

    do_txn(16'h0001, 16'h0000, 16'h0000, 16'h0000, 1);
    check_eq("sb_empty", longint'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/da_rom_sequencer.md
Name: da_rom_sequencer

Overview:
Sequences the 4-input distributed-arithmetic coefficient ROM used in the DCT datapath.
- Accepts one group of four two's-complement samples.
- Walks their bit-slices MSB-first, driving the ROM chip-select and 4-bit address.
- Shift-accumulates the combinational ROM word into a full-precision signed dot-product result.
- Returns the result over a valid/ready handshake.

Parameters:
IN_W, 16, sample width in bits (two's complement), also the number of bit-slices per operation; legal range 2..32
ROM_W, 17, ROM data width (unsigned fixed point, 3 integer + 14 fraction bits)
ACC_W, IN_W+ROM_W+1, signed accumulator/result width; no truncation or saturation

Ports:
clk  in  1  single clock; all flops on posedge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  sample group valid
in_ready  out  1  block can accept a sample group
x0  in  IN_W  sample 0, drives rom_addr[0]
x1  in  IN_W  sample 1, drives rom_addr[1]
x2  in  IN_W  sample 2, drives rom_addr[2]
x3  in  IN_W  sample 3, drives rom_addr[3]
rom_cs  out  1  ROM chip select, registered
rom_addr  out  4  ROM address = {x3[j],x2[j],x1[j],x0[j]} for current bit j, registered
rom_data  in  ROM_W  ROM word, combinational from rom_addr
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  ACC_W  signed result = sum over k of xk * coef(k) in ROM fixed-point scale

Behaviour:
- Reset (async assert) values:
  - State IDLE; in_ready=0, rom_cs=0, rom_addr=0, out_valid=0, out_data=0.
  - Accumulator, sample registers and bit counter all 0.
- Reset release:
  - in_ready stays 0 until the first posedge after rst_n deasserts, then goes 1 in IDLE.
  - This covers the ROM's own synchronised reset release.
- IDLE:
  - in_ready=1, rom_cs=0, rom_addr=0.
  - On in_valid&&in_ready: capture x0..x3, set bit counter j=IN_W-1, rom_cs<=1, rom_addr<=MSB slice, go to RUN.
- RUN (exactly IN_W cycles):
  - in_ready=0.
  - Each posedge samples rom_data for the address driven during the preceding cycle.
  - First RUN edge (j=IN_W-1, sign slice): acc <= -zext(rom_data).
  - Later edges: acc <= (acc<<1) + zext(rom_data).
  - After each edge, rom_addr advances to slice j-1.
  - At the edge consuming slice 0:
    - out_data <= final acc, out_valid<=1.
    - rom_cs<=0, rom_addr<=0.
    - Go to DONE.
- DONE:
  - out_valid=1; out_data held stable; in_ready=0; rom_cs=0.
  - On out_ready: out_valid<=0, go to IDLE.
  - out_data keeps its last value until overwritten.
- Arithmetic:
  - rom_data is zero-extended to ACC_W.
  - All adds/subtracts are signed ACC_W, performed in full precision.
  - The ACC_W range guarantees no overflow for any inputs.
- Timing:
  - Latency from accepting edge to out_valid high: IN_W cycles.
  - Minimum initiation interval: IN_W+2 cycles (accept, IN_W RUN edges, one DONE edge with out_ready=1).
- in_valid in RUN/DONE: ignored, not captured. Samples may change freely after acceptance.
- out_ready while out_valid=0: no effect.
- rst_n assertion in any state, including mid-RUN:
  - Immediate return to reset values.
  - Partial result discarded; no out_valid pulse.
- Coefficient constants for checking: c4 word 11585 (0x2D41), 2c4 23170 (0x5A82), 3c4 34755 (0x87C3), 4c4 46340 (0xB504).

Test Plan:
- x0=1, x1=x2=x3=0 -> rom_addr 0 for 15 RUN cycles then 4'b0001; out_data=11585 exactly 16 cycles after accept.
- x0=x1=x2=x3=1 -> last slice addr 4'b1111; out_data=46340.
- x0=16'hFFFF (-1), others 0 -> sign slice subtracted; out_data=-11585.
- x0..x3=16'h8000 -> only sign slice nonzero; out_data=-46340*32768=-1518469120; no overflow in 34 bits.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid:
  - out_valid and out_data remain stable; in_ready=0; a new in_valid is not taken.
  - Raise out_ready: next cycle IDLE, in_ready=1.
- Reset mid-RUN (at j=7): all outputs 0 immediately, rom_cs=0, no out_valid.
  - in_ready stays 0 until the first posedge after release.
  - A following transaction x0=1 returns 11585.
